// File: rtl/fft_stream_pkg.sv
// Shared definitions for the FFT streaming framer: FSM encoding, default sizes
// and the width of a squared-magnitude power value.
package fft_stream_pkg;

    typedef logic [0:0] framer_state_t;

    localparam framer_state_t ST_IDLE = 1'b0;
    localparam framer_state_t ST_RUN  = 1'b1;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_OUT_W    = 25;
    localparam int DEF_LOG2_PTS = 10;
    localparam int DEF_FIFO_AW  = 4;

    // re^2 + im^2 of two signed OUT_W values needs one carry bit above 2*OUT_W.
    function automatic int POW_W(input int out_w);
        return 2 * out_w + 1;
    endfunction

endpackage

// File: rtl/fft_sample_fifo.sv
// Show-ahead synchronous FIFO buffering audio samples ahead of the FFT core.
module fft_sample_fifo
    import fft_stream_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FIFO_AW = DEF_FIFO_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [FIFO_AW:0]  count
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Fullness is judged on the start-of-cycle count, so a same-cycle pop never makes room.
    assign full    = (count == (FIFO_AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_stream_framer.sv
// Frames an unstallable audio stream into N-point FFT input frames and picks the
// strongest positive-frequency bin from each complete output frame.
module fft_stream_framer
    import fft_stream_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int LOG2_PTS = DEF_LOG2_PTS,
    parameter int FIFO_AW  = DEF_FIFO_AW
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        sink_valid,
    input  logic                        sink_ready,
    output logic                        sink_sop,
    output logic                        sink_eop,
    output logic [DATA_W-1:0]           sink_real,
    output logic [DATA_W-1:0]           sink_imag,
    output logic [LOG2_PTS:0]           fftpts,
    input  logic                        source_valid,
    output logic                        source_ready,
    input  logic                        source_sop,
    input  logic                        source_eop,
    input  logic signed [OUT_W-1:0]     source_real,
    input  logic signed [OUT_W-1:0]     source_imag,
    output logic                        peak_valid,
    output logic [LOG2_PTS-1:0]         peak_bin,
    output logic [POW_W(OUT_W)-1:0]     peak_power,
    output logic                        overflow,
    output logic                        frame_error
);

    localparam int PW = POW_W(OUT_W);
    localparam int N  = 1 << LOG2_PTS;
    localparam logic [LOG2_PTS-1:0] LAST_IDX = '1;

    logic [DATA_W-1:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_AW:0]    fifo_count;
    framer_state_t       state;
    logic [LOG2_PTS-1:0] index;
    logic                sink_beat;

    fft_sample_fifo #(
        .DATA_W  (DATA_W),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid),
        .wdata   (in_data),
        .pop     (sink_beat),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assert property (@(posedge clk) disable iff (!reset_n) fifo_empty == (fifo_count == '0));

    // Sideband is qualified by sink_valid so everything reads zero when nothing is offered.
    assign sink_valid = (state == ST_RUN) && !fifo_empty;
    assign sink_beat  = sink_valid && sink_ready;
    assign sink_real  = sink_valid ? fifo_rdata : '0;
    assign sink_sop   = sink_valid && (index == '0);
    assign sink_eop   = sink_valid && (index == LAST_IDX);
    assign sink_imag  = '0;
    assign fftpts     = (LOG2_PTS + 1)'(N);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            index    <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_valid && fifo_full) begin
                overflow <= 1'b1;
            end
            if (sink_beat) begin
                index <= index + LOG2_PTS'(1);
            end
            case (state)
                ST_IDLE: if (enable) state <= ST_RUN;
                ST_RUN:  if (sink_beat && (index == LAST_IDX) && !enable) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [LOG2_PTS-1:0]        bin_cnt;
    logic [LOG2_PTS-1:0]        beat_bin;
    logic signed [2*OUT_W-1:0]  re_sq;
    logic signed [2*OUT_W-1:0]  im_sq;
    logic [PW-1:0]              beat_pow;
    logic                       p1_valid;
    logic                       p1_sop;
    logic                       p1_eop;
    logic [LOG2_PTS-1:0]        p1_bin;
    logic [PW-1:0]              p1_pow;

    assign beat_bin = source_sop ? '0 : bin_cnt;
    assign re_sq    = source_real * source_real;
    assign im_sq    = source_imag * source_imag;
    assign beat_pow = {1'b0, re_sq} + {1'b0, im_sq};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            source_ready <= 1'b0;
            bin_cnt      <= '0;
            p1_valid     <= 1'b0;
            p1_sop       <= 1'b0;
            p1_eop       <= 1'b0;
            p1_bin       <= '0;
            p1_pow       <= '0;
        end else begin
            source_ready <= 1'b1;
            p1_valid     <= source_valid;
            if (source_valid) begin
                bin_cnt <= beat_bin + LOG2_PTS'(1);
                p1_sop  <= source_sop;
                p1_eop  <= source_eop;
                p1_bin  <= beat_bin;
                p1_pow  <= beat_pow;
            end
        end
    end

    logic [PW-1:0]       max_pow;
    logic [PW-1:0]       nxt_pow;
    logic [LOG2_PTS-1:0] max_bin;
    logic [LOG2_PTS-1:0] nxt_bin;
    logic                candidate;

    // Only bins 1..N/2-1 compete; strict compare keeps the lower bin on ties.
    assign candidate = (p1_bin != '0) && !p1_bin[LOG2_PTS-1];

    always_comb begin
        nxt_pow = p1_sop ? '0 : max_pow;
        nxt_bin = p1_sop ? '0 : max_bin;
        if (candidate && (p1_pow > nxt_pow)) begin
            nxt_pow = p1_pow;
            nxt_bin = p1_bin;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            max_pow     <= '0;
            max_bin     <= '0;
            peak_valid  <= 1'b0;
            peak_bin    <= '0;
            peak_power  <= '0;
            frame_error <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            if (p1_valid) begin
                max_pow <= nxt_pow;
                max_bin <= nxt_bin;
                if (p1_eop) begin
                    if (p1_bin == LAST_IDX) begin
                        peak_valid <= 1'b1;
                        peak_bin   <= nxt_bin;
                        peak_power <= nxt_pow;
                    end else begin
                        frame_error <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_stream_framer.sv
// Randomised scoreboard bench for fft_stream_framer with a queue-based reference model.
module tb_fft_stream_framer;

    localparam int DATA_W   = 16;
    localparam int OUT_W    = 25;
    localparam int LOG2_PTS = 4;
    localparam int FIFO_AW  = 2;
    localparam int N        = 16;
    localparam int DEPTH    = 4;
    localparam int PW       = 2 * OUT_W + 1;

    typedef struct {
        int     bin;
        longint pow;
        int     due;
    } peak_t;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     enable = 1'b0;
    logic                     in_valid = 1'b0;
    logic [DATA_W-1:0]        in_data = '0;
    logic                     sink_valid;
    logic                     sink_ready = 1'b0;
    logic                     sink_sop;
    logic                     sink_eop;
    logic [DATA_W-1:0]        sink_real;
    logic [DATA_W-1:0]        sink_imag;
    logic [LOG2_PTS:0]        fftpts;
    logic                     source_valid = 1'b0;
    logic                     source_ready;
    logic                     source_sop = 1'b0;
    logic                     source_eop = 1'b0;
    logic signed [OUT_W-1:0]  source_real = '0;
    logic signed [OUT_W-1:0]  source_imag = '0;
    logic                     peak_valid;
    logic [LOG2_PTS-1:0]      peak_bin;
    logic [PW-1:0]            peak_power;
    logic                     overflow;
    logic                     frame_error;

    fft_stream_framer #(
        .DATA_W   (DATA_W),
        .OUT_W    (OUT_W),
        .LOG2_PTS (LOG2_PTS),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .fftpts       (fftpts),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .peak_valid   (peak_valid),
        .peak_bin     (peak_bin),
        .peak_power   (peak_power),
        .overflow     (overflow),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model state: samples owed to the sink, frame position, flags, pending peaks.
    logic [DATA_W-1:0]       exp_q[$];
    peak_t                   peak_q[$];
    int                      m_idx = 0;
    bit                      m_run = 0;
    bit                      m_ov = 0;
    bit                      m_fe = 0;
    bit                      m_sr = 0;
    int                      m_pbin = 0;
    longint                  m_ppow = 0;
    bit                      hold = 0;
    logic [DATA_W-1:0]       prev_real = '0;
    logic                    prev_sop = 1'b0;
    logic                    prev_eop = 1'b0;
    int                      sop_seen = 0;
    int                      eop_seen = 0;
    int                      pulses_seen = 0;
    int                      poison_seen = 0;
    logic signed [OUT_W-1:0] fr_re [N];
    logic signed [OUT_W-1:0] fr_im [N];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_vectors++;
        if (actual != expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit iv, input logic [DATA_W-1:0] d, input bit rdy, input bit en);
        in_valid   = iv;
        in_data    = d;
        sink_ready = rdy;
        enable     = en;
        tick();
    endtask

    function automatic peak_t refPeak(input int due);
        peak_t p;
        p.bin = 0;
        p.pow = 0;
        p.due = due;
        for (int b = 1; b < N / 2; b++) begin
            longint pw;
            pw = longint'(fr_re[b]) * longint'(fr_re[b]) + longint'(fr_im[b]) * longint'(fr_im[b]);
            if (pw > p.pow) begin
                p.bin = b;
                p.pow = pw;
            end
        end
        return p;
    endfunction

    task automatic clearFrame();
        for (int b = 0; b < N; b++) begin
            fr_re[b] = '0;
            fr_im[b] = '0;
        end
    endtask

    task automatic fillRandom(input bit wide);
        for (int b = 0; b < N; b++) begin
            if (wide) begin
                fr_re[b] = OUT_W'($urandom);
                fr_im[b] = OUT_W'($urandom);
            end else begin
                fr_re[b] = OUT_W'(int'($urandom_range(0, 4000)) - 2000);
                fr_im[b] = OUT_W'(int'($urandom_range(0, 4000)) - 2000);
            end
        end
    endtask

    // Plays fr_re/fr_im as one core frame; expectations are queued as the eop is issued.
    task automatic sendCoreFrame(input int len, input bit with_eop, input bit gaps);
        for (int b = 0; b < len; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                source_valid = 1'b0;
                source_sop   = 1'b0;
                source_eop   = 1'b0;
                tick();
            end
            source_valid = 1'b1;
            source_sop   = (b == 0);
            source_eop   = with_eop && (b == len - 1);
            source_real  = fr_re[b];
            source_imag  = fr_im[b];
            if (source_eop) begin
                if (len == N) peak_q.push_back(refPeak(cyc + 2));
                else m_fe = 1;
            end
            tick();
        end
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        source_real  = '0;
        source_imag  = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sink_valid"}, sink_valid, 0);
        checkOutput({tag, "_sink_sop"}, sink_sop, 0);
        checkOutput({tag, "_sink_eop"}, sink_eop, 0);
        checkOutput({tag, "_sink_real"}, sink_real, 0);
        checkOutput({tag, "_sink_imag"}, sink_imag, 0);
        checkOutput({tag, "_fftpts"}, fftpts, N);
        checkOutput({tag, "_source_ready"}, source_ready, 0);
        checkOutput({tag, "_peak_valid"}, peak_valid, 0);
        checkOutput({tag, "_peak_bin"}, peak_bin, 0);
        checkOutput({tag, "_peak_power"}, peak_power, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
        checkOutput({tag, "_frame_error"}, frame_error, 0);
    endtask

    // Monitor: mid-cycle sampling, compares DUT against the model and advances the model.
    always @(negedge clk) begin : monitor
        int occ;
        bit exp_valid;
        bit beat;
        if (!reset_n) begin
            exp_q.delete();
            peak_q.delete();
            m_idx  = 0;
            m_run  = 0;
            m_ov   = 0;
            m_fe   = 0;
            m_sr   = 0;
            m_pbin = 0;
            m_ppow = 0;
            hold   = 0;
        end else begin
            checkOutput("source_ready", source_ready, m_sr);
            m_sr = 1;
            checkOutput("overflow", overflow, m_ov);
            occ = exp_q.size();
            exp_valid = m_run && (occ > 0);
            checkOutput("sink_valid", sink_valid, exp_valid);
            if (hold) begin
                checkOutput("hold_real", sink_real, prev_real);
                checkOutput("hold_sop", sink_sop, prev_sop);
                checkOutput("hold_eop", sink_eop, prev_eop);
            end
            beat = sink_valid && sink_ready;
            if (beat && occ > 0) begin
                checkOutput("beat_data", sink_real, exp_q[0]);
                checkOutput("beat_sop", sink_sop, m_idx == 0);
                checkOutput("beat_eop", sink_eop, m_idx == N - 1);
                void'(exp_q.pop_front());
                if (sink_sop) sop_seen++;
                if (sink_eop) eop_seen++;
                if (sink_real == 16'h7004) poison_seen++;
            end
            if (m_run) begin
                if (beat && m_idx == N - 1 && !enable) m_run = 0;
            end else if (enable) begin
                m_run = 1;
            end
            if (beat) m_idx = (m_idx + 1) % N;
            hold      = sink_valid && !sink_ready;
            prev_real = sink_real;
            prev_sop  = sink_sop;
            prev_eop  = sink_eop;
            if (in_valid) begin
                if (occ < DEPTH) exp_q.push_back(in_data);
                else m_ov = 1;
            end
            while (peak_q.size() > 0 && peak_q[0].due < cyc) begin
                checkOutput("peak_pulse_at_due", cyc, peak_q[0].due);
                void'(peak_q.pop_front());
            end
            if (peak_valid) begin
                if (peak_q.size() > 0) begin
                    checkOutput("peak_pulse_time", cyc, peak_q[0].due);
                    m_pbin = peak_q[0].bin;
                    m_ppow = peak_q[0].pow;
                    void'(peak_q.pop_front());
                    pulses_seen++;
                end else begin
                    checkOutput("peak_pulse_unexpected", peak_valid, 0);
                end
            end
            checkOutput("peak_bin", peak_bin, m_pbin);
            checkOutput("peak_power", peak_power, m_ppow);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] d;
        int budget;
        int stall;
        bit stalled;
        bit en_r;
        int target;
        int sop_before;

        d = 16'h0100;
        reset_n = 1'b0;
        repeat (3) tick();
        checkResetOutputs("reset");
        reset_n = 1'b1;

        // One full frame, ready always high.
        for (int i = 0; i < 16; i++) applyStimulus(1, DATA_W'(i * 37 + 5), 1, 1);
        repeat (4) applyStimulus(0, '0, 1, 1);
        checkOutput("frame1_sop_count", sop_seen, 1);
        checkOutput("frame1_eop_count", eop_seen, 1);
        checkOutput("fftpts", fftpts, N);

        // Back-pressure for three cycles when beat 5 is next.
        budget = 0;
        stall = 0;
        stalled = 0;
        while (eop_seen < 2 && budget < 100) begin
            if (!stalled && m_idx == 5) begin
                stall = 3;
                stalled = 1;
            end
            if (stall > 0) begin
                stall--;
                applyStimulus(0, '0, 0, 1);
            end else begin
                applyStimulus(1, d, 1, 1);
                d++;
            end
            budget++;
        end
        repeat (4) applyStimulus(0, '0, 1, 1);
        checkOutput("frame2_eop_count", eop_seen, 2);

        // Five pushes into a stalled four-deep FIFO.
        checkOutput("overflow_before", overflow, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, DATA_W'(16'h7000 + i), 0, 1);
        checkOutput("overflow_set", overflow, 1);
        repeat (6) applyStimulus(0, '0, 1, 1);
        checkOutput("dropped_sample_absent", poison_seen, 0);
        checkOutput("fifo_drained_valid", sink_valid, 0);

        // enable drops when beat 7 is next; the frame must still run to its eop.
        target = eop_seen + 1;
        en_r = 1;
        budget = 0;
        while (eop_seen < target && budget < 100) begin
            if (m_idx == 7) en_r = 0;
            applyStimulus(1, d, 1, en_r);
            d++;
            budget++;
        end
        repeat (6) begin
            applyStimulus(1, d, 1, 0);
            d++;
        end
        checkOutput("stop_eop_count", eop_seen, target);
        checkOutput("stopped_valid", sink_valid, 0);
        applyStimulus(0, '0, 1, 0);

        // Output side: DC must be ignored.
        clearFrame();
        fr_re[3] = 100;
        fr_re[0] = 30000;
        sendCoreFrame(N, 1, 0);
        repeat (4) tick();
        checkOutput("dc_ignored_bin", peak_bin, 3);
        checkOutput("dc_ignored_power", peak_power, 10000);
        checkOutput("dc_ignored_pulses", pulses_seen, 1);

        // Tie between bins 2 and 5 keeps the lower bin.
        clearFrame();
        fr_re[2] = 7; fr_im[2] = 7;
        fr_re[5] = 7; fr_im[5] = 7;
        sendCoreFrame(N, 1, 1);
        repeat (4) tick();
        checkOutput("tie_bin", peak_bin, 2);
        checkOutput("tie_power", peak_power, 98);
        checkOutput("tie_pulses", pulses_seen, 2);
        checkOutput("frame_error_clean", frame_error, 0);

        // Short frame: eop at bin 9.
        fillRandom(0);
        sendCoreFrame(10, 1, 0);
        repeat (4) tick();
        checkOutput("short_frame_error", frame_error, 1);
        checkOutput("short_frame_bin_kept", peak_bin, 2);
        checkOutput("short_frame_power_kept", peak_power, 98);
        checkOutput("short_frame_no_pulse", pulses_seen, 2);

        // Abandoned partial frame followed by a fresh sop.
        fillRandom(1);
        sendCoreFrame(5, 0, 0);
        fillRandom(1);
        sendCoreFrame(N, 1, 0);
        repeat (4) tick();
        checkOutput("restart_pulses", pulses_seen, 3);

        // Random traffic on both sides at once.
        en_r = 1;
        fork
            begin
                for (int c = 0; c < 700; c++) begin
                    if ($urandom_range(0, 39) == 0) en_r = !en_r;
                    applyStimulus($urandom_range(0, 9) < 4, DATA_W'($urandom), $urandom_range(0, 3) != 0, en_r);
                end
            end
            begin
                for (int f = 0; f < 14; f++) begin
                    int kind;
                    kind = $urandom_range(0, 9);
                    fillRandom($urandom_range(0, 1) == 1);
                    if (kind == 0) sendCoreFrame($urandom_range(2, 15), 0, 1);
                    else if (kind == 1) sendCoreFrame($urandom_range(1, 15), 1, 1);
                    else sendCoreFrame(N, 1, 1);
                    repeat ($urandom_range(0, 3)) tick();
                end
            end
        join
        repeat (4) applyStimulus(0, '0, 1, 1);
        checkOutput("random_frame_error", frame_error, m_fe);

        // Mid-frame reset when beat 4 is next, then a clean frame from sop.
        budget = 0;
        while (m_idx != 4 && budget < 200) begin
            applyStimulus(1, d, 1, 1);
            d++;
            budget++;
        end
        reset_n = 1'b0;
        applyStimulus(1, d, 1, 1);
        reset_n = 1'b1;
        checkResetOutputs("midreset");
        sop_before = sop_seen;
        for (int i = 0; i < 16; i++) applyStimulus(1, DATA_W'(16'h0A00 + i), 1, 1);
        repeat (4) applyStimulus(0, '0, 1, 1);
        checkOutput("post_reset_sop_count", sop_seen, sop_before + 1);

        fillRandom(0);
        sendCoreFrame(N, 1, 0);
        repeat (4) tick();
        checkOutput("pending_peaks", peak_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
